// File: rtl/seg_scan_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg_scan_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Entry 15 sits in the most significant slot, entry 0 in the least.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        DIG_SUM    = 2'd0,
        DIG_COUT   = 2'd1,
        DIG_CNT_LO = 2'd2,
        DIG_CNT_HI = 2'd3
    } digit_e;

    function automatic logic [3:0] an_sel(input digit_e d);
        logic [3:0] onehot;
        onehot = 4'b0001 << d;
        return ~onehot;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Pure table lookup so the top can register the result directly.
module hex_to_seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit scanned display of a captured adder result and a load count.
// Digit 1 blinks while a carry-out is latched.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int RW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] RND_LAST = RW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    digit_e        dig_q, dig_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          blink_q, blink_d;

    logic [3:0]    sum_q, sum_d;
    logic          cout_q, cout_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    dec_seg;

    assign tick = (pre_q == PRE_LAST);
    assign wrap = tick && (dig_q == DIG_CNT_HI);

    always_comb begin
        pre_d   = pre_q + 1'b1;
        dig_d   = dig_q;
        rnd_d   = rnd_q;
        blink_d = blink_q;
        if (tick) begin
            pre_d = '0;
            dig_d = digit_e'(dig_q + 2'd1);
        end
        // Blink phase flips once every BLINK_DIV complete scan rounds.
        if (wrap) begin
            if (rnd_q == RND_LAST) begin
                rnd_d   = '0;
                blink_d = ~blink_q;
            end else begin
                rnd_d = rnd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            dig_q   <= DIG_SUM;
            rnd_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            dig_q   <= dig_d;
            rnd_q   <= rnd_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        cnt_d  = cnt_q;
        if (load) begin
            sum_d  = sum;
            cout_d = cout;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        unique case (dig_q)
            DIG_SUM:    nib = sum_q;
            DIG_COUT: begin
                nib   = {3'b000, cout_q};
                blank = cout_q & blink_q;
            end
            DIG_CNT_LO: nib = cnt_q[3:0];
            DIG_CNT_HI: nib = cnt_q[7:4];
            default:    nib = '0;
        endcase
    end

    hex_to_seg u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = blank ? SEG_BLANK : dec_seg;
        an_d  = an_sel(dig_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display against a slot-arithmetic model.
// Expected outputs derive from edge count since reset and captured data.
module tb_seg_scan_display;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] sum = 4'h0;
    logic       cout = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    seg_scan_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .sum   (sum),
        .cout  (cout),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int         n_chk = 0;
    int         n_pass = 0;
    int         e;
    int         m_cnt;
    logic [3:0] m_sum;
    logic       m_cout;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    int         exp_dig;

    task automatic model_reset();
        e      = 0;
        m_cnt  = 0;
        m_sum  = 4'h0;
        m_cout = 1'b0;
    endtask

    // Output after edge e reflects state after edge e-1: slot = (e-1)/SD.
    task automatic step(input logic ld, input logic [3:0] s, input logic c);
        int sl;
        int bl;
        int v;
        load = ld;
        sum  = s;
        cout = c;
        @(posedge clk);
        #1;
        e++;
        sl = (e - 1) / SD;
        exp_dig = sl % 4;
        bl = ((sl / 4) / BD) % 2;
        case (exp_dig)
            0:       v = m_sum;
            1:       v = m_cout;
            2:       v = m_cnt % 16;
            default: v = m_cnt / 16;
        endcase
        if (exp_dig == 1 && m_cout && bl == 1) exp_seg = 7'b1111111;
        else exp_seg = tbl[v];
        exp_an = 4'hF ^ (4'b0001 << exp_dig);
        if (ld) begin
            m_sum  = s;
            m_cout = c;
            m_cnt  = (m_cnt + 1) % 256;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        #13;
        n_chk++;
        if (seg !== 7'b1111111) $display("FAIL rst_seg got %b want 1111111", seg);
        else n_pass++;
        n_chk++;
        if (an !== 4'b1111) $display("FAIL rst_an got %b want 1111", an);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 4'h0, 1'b0);
        n_chk++;
        if (seg !== 7'b1000000) $display("FAIL rel_seg got %b want 1000000", seg);
        else n_pass++;
        n_chk++;
        if (an !== 4'b1110) $display("FAIL rel_an got %b want 1110", an);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'h0, 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL rst_idle e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
        end
    endtask

    task automatic test_capture_scan();
        do_reset();
        step(1'b1, 4'hA, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'($urandom), 1'($urandom));
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL cap e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
            if (exp_dig == 0 && e > 2) begin
                n_chk++;
                if (seg !== 7'b0001000) $display("FAIL cap_d0 e=%0d got %b want 0001000", e, seg);
                else n_pass++;
            end
            if (exp_dig == 1) begin
                n_chk++;
                if (seg !== 7'b1000000) $display("FAIL cap_d1 e=%0d got %b want 1000000", e, seg);
                else n_pass++;
            end
        end
    endtask

    task automatic run_wrap(input int nloads, input logic [6:0] want);
        do_reset();
        for (int i = 0; i < nloads; i++) begin
            step(1'b1, 4'($urandom), 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL wrap_ld e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'h0, 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL wrap e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
            if (exp_dig >= 2) begin
                n_chk++;
                if (seg !== want) $display("FAIL wrap_cnt n=%0d got %b want %b", nloads, seg, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_counter_wrap();
        run_wrap(256, 7'b1000000);
        run_wrap(255, 7'b0001110);
    endtask

    task automatic test_blink();
        logic [3:0] s;
        s = 4'($urandom);
        do_reset();
        step(1'b1, s, 1'b1);
        for (int i = 0; i < 140; i++) begin
            step(1'b0, 4'h0, 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL blink e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
            if (exp_dig == 0 && e > 2) begin
                n_chk++;
                if (seg !== tbl[s]) $display("FAIL blink_d0 e=%0d got %b want %b", e, seg, tbl[s]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_coincidence();
        int guard;
        do_reset();
        guard = 0;
        while (e % SD != SD - 1 && guard < 16) begin
            step(1'b0, 4'h0, 1'b0);
            guard++;
        end
        step(1'b1, 4'h7, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 4'h0, 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL coin e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
            if (exp_dig == 0) begin
                n_chk++;
                if (seg !== 7'b1111000) $display("FAIL coin_d0 e=%0d got %b want 1111000", e, seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom));
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL rand e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        do_reset();
        step(1'b1, 4'h5, 1'b1);
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'h3, 1'b1);
        guard = 0;
        while (exp_dig != 2 && guard < 32) begin
            step(1'b0, 4'h0, 1'b0);
            guard++;
        end
        n_chk++;
        if (an !== 4'b1011) $display("FAIL mid_slot2 got %b want 1011", an);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (seg !== 7'b1111111) $display("FAIL mid_seg got %b want 1111111", seg);
        else n_pass++;
        n_chk++;
        if (an !== 4'b1111) $display("FAIL mid_an got %b want 1111", an);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'h0, 1'b0);
            n_chk++;
            if (seg !== exp_seg || an !== exp_an)
                $display("FAIL mid e=%0d got %b/%b want %b/%b", e, seg, an, exp_seg, exp_an);
            else n_pass++;
            if (exp_dig == 2) begin
                n_chk++;
                if (seg !== 7'b1000000) $display("FAIL mid_cnt e=%0d got %b want 1000000", e, seg);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        exp_seg = 7'b1111111;
        exp_an  = 4'b1111;
        exp_dig = 0;
        test_reset();
        test_capture_scan();
        test_counter_wrap();
        test_blink();
        test_coincidence();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
